// File: rtl/dragster_pkg.sv
// dragster_pkg: frame geometry, register map, FSM states and address check.
package dragster_pkg;
  localparam int FRAME_BITS = 16;
  localparam int ADDR_BITS = 8;
  localparam int READ_FLAG_BIT = 7;
  localparam int UPDATE_BIT = 7;
  localparam logic [3:0] CTRL1 = 4'd1;
  localparam logic [3:0] CTRL2 = 4'd2;
  localparam logic [3:0] ADC_GAIN = 4'd3;
  localparam logic [3:0] CTRL3 = 4'd5;
  localparam logic [3:0] ADC_END = 4'd9;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, WAIT_END} state_t;
  function automatic logic addr_ok(input logic [6:0] a, input int n);
    return a[6:4] == 3'b000 && int'(a[3:0]) < n;
  endfunction
endpackage

// File: rtl/dragster_sync.sv
// dragster_sync: multi-flop synchronizer for one asynchronous input bit.
module dragster_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  logic [STAGES:0] sh;
  assign sh = {ff, d};
  assign q = ff[STAGES-1];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) ff <= '0;
    else ff <= sh[STAGES-1:0];
endmodule

// File: rtl/dragster_spi_responder.sv
// dragster_spi_responder: SPI mode-0 register responder (16-bit LSB-first frames).
// Define DRAGSTER_READBACK_EN to let read frames return register contents on miso.
module dragster_spi_responder
  import dragster_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sclk,
  input  logic       ss_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic       wr_strobe,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       update_pulse,
  output logic       frame_error
);
  localparam int IW = $clog2(NUM_REGS);
  state_t state, state_nx;
  logic sclk_s, ss_s, mosi_s, sclk_d, ss_d;
  logic rise, ss_fall, ss_rise, abort, to_data, done, wr_go;
  logic [3:0] bit_cnt;
  logic [7:0] sh, addr_q, rx_byte;
  logic [NUM_REGS-1:0][7:0] regs;
  dragster_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (.clk(clk), .reset_n(reset_n), .d(sclk), .q(sclk_s));
  dragster_sync #(.STAGES(SYNC_STAGES)) u_sync_ss (.clk(clk), .reset_n(reset_n), .d(ss_n), .q(ss_s));
  dragster_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (.clk(clk), .reset_n(reset_n), .d(mosi), .q(mosi_s));
  always_comb begin
    rise = sclk_s & ~sclk_d;
    ss_fall = ~ss_s & ss_d;
    ss_rise = ss_s & ~ss_d;
    abort = (state == ADDR || state == DATA) && ss_rise;
    rx_byte = {mosi_s, sh[7:1]};
    to_data = state == ADDR && rise && !ss_rise && bit_cnt == 4'(ADDR_BITS - 1);
    done = state == DATA && rise && !ss_rise && bit_cnt == 4'(FRAME_BITS - 1);
    wr_go = done && !addr_q[READ_FLAG_BIT] && addr_ok(addr_q[6:0], NUM_REGS);
    state_nx = abort ? IDLE :
               to_data ? DATA :
               done ? WAIT_END :
               (state == IDLE && ss_fall) ? ADDR :
               (state == WAIT_END && ss_rise) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sclk_d <= 1'b0;
      ss_d <= 1'b0;
      bit_cnt <= '0;
      sh <= '0;
      addr_q <= '0;
      regs <= '0;
      wr_strobe <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      update_pulse <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      sclk_d <= sclk_s;
      ss_d <= ss_s;
      if (state == IDLE && ss_fall) bit_cnt <= '0;
      else if (rise && (state == ADDR || state == DATA)) begin
        bit_cnt <= bit_cnt + 4'd1;
        sh <= rx_byte;
      end
      if (to_data) addr_q <= rx_byte;
      if (wr_go) begin
        regs[addr_q[IW-1:0]] <= rx_byte;
        wr_addr <= addr_q[3:0];
        wr_data <= rx_byte;
      end
      wr_strobe <= wr_go;
      update_pulse <= wr_go && addr_q[3:0] == CTRL1 && rx_byte[UPDATE_BIT];
      frame_error <= abort || (done && !addr_ok(addr_q[6:0], NUM_REGS));
    end
`ifdef DRAGSTER_READBACK_EN
  logic fall, miso_q;
  logic [7:0] tx;
  assign fall = ~sclk_s & sclk_d;
  assign miso = miso_q;
  assign miso_oe = state != IDLE && !ss_s;
  // tx is loaded at the end of the address byte, so the first data bit is ready for the next falling edge
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      tx <= '0;
      miso_q <= 1'b0;
    end else begin
      if (to_data) tx <= (rx_byte[READ_FLAG_BIT] && addr_ok(rx_byte[6:0], NUM_REGS)) ? regs[rx_byte[IW-1:0]] : 8'h00;
      else if (fall && state == DATA) tx <= tx >> 1;
      miso_q <= (state == DATA && !ss_s) ? (fall ? tx[0] : miso_q) : 1'b0;
    end
`else
  logic unused_regs;
  assign unused_regs = ^regs;
  assign miso = 1'b0;
  assign miso_oe = 1'b0;
`endif
endmodule

// File: doc/dragster_spi_responder.md
DRAGSTER_SPI_RESPONDER -- requirements
Module: dragster_spi_responder

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, number of 8-bit registers (2..16).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on sclk/ss_n/mosi.
REQ-003 SHALL have port clk, input, 1, single system clock; all logic on posedge clk.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port sclk, input, 1, SPI clock from master, mode 0 (CPOL=0, CPHA=0).
REQ-006 SHALL have port ss_n, input, 1, active-low slave select.
REQ-007 SHALL have port mosi, input, 1, serial data in.
REQ-008 SHALL have port miso, output, 1, serial data out.
REQ-009 SHALL have port miso_oe, output, 1, miso drive enable, high only while ss_n low.
REQ-010 SHALL have port wr_strobe, output, 1, one-clk pulse per accepted register write.
REQ-011 SHALL have port wr_addr, output, 4, address of accepted write, valid with wr_strobe.
REQ-012 SHALL have port wr_data, output, 8, data of accepted write, valid with wr_strobe.
REQ-013 SHALL have port update_pulse, output, 1, one-clk pulse on write to address 1 with data bit 7 set.
REQ-014 SHALL have port frame_error, output, 1, one-clk pulse on aborted or malformed frame.

Function
REQ-015 Frame: 16 bits, LSB first; bits 0-7 address byte, bits 8-15 data byte; matches a master sending {data, addr} LSB first.
REQ-016 Address byte: bit 7 = read flag (1 read, 0 write), bits 3:0 = register index, bits 6:4 SHALL be zero.
REQ-017 sclk, ss_n, mosi SHALL pass through SYNC_STAGES flops; edges detected on synchronized sclk; clk SHALL be >= 8x sclk.
REQ-018 mosi SHALL be sampled on synchronized sclk rising edge; miso SHALL change on synchronized sclk falling edge.
REQ-019 FSM states: IDLE, ADDR, DATA, WAIT_END.
REQ-020 IDLE -> ADDR on ss_n falling; bit counter cleared.
REQ-021 ADDR -> DATA after 8th rising edge; address latched; for reads, data shift register loaded with regs[index] before first DATA falling edge.
REQ-022 DATA -> WAIT_END after 16th rising edge; write frames with valid index update regs[index] and pulse wr_strobe on the next clk.
REQ-023 WAIT_END: extra sclk edges ignored, no further writes; -> IDLE on ss_n rising.
REQ-024 ss_n rising in ADDR or DATA SHALL abort: no write, frame_error pulse, -> IDLE.
REQ-025 Index >= NUM_REGS or nonzero bits 6:4: write discarded, read returns 0x00, frame_error pulses at 16th bit.
REQ-026 miso SHALL be 0 during ADDR, for write frames, and when ss_n high.
REQ-027 Read frames SHALL NOT modify registers or pulse wr_strobe.

Reset
REQ-028 reset_n low SHALL asynchronously force FSM to IDLE, bit counter 0, all registers 0x00, all outputs 0.
REQ-029 Reset mid-frame SHALL discard the frame; after release responder waits for a fresh ss_n falling edge.

Configuration
REQ-030 Macro DRAGSTER_READBACK_EN defined: read frames return register contents per REQ-021.
REQ-031 Macro undefined: read frames discarded silently, miso and miso_oe held 0, no read mux synthesized.

Structure
REQ-032 Package dragster_pkg SHALL hold FRAME_BITS=16, ADDR_BITS=8, READ_FLAG_BIT=7, register address constants (CTRL1=1, CTRL2=2, ADC_GAIN=3, CTRL3=5, ADC_END=9), UPDATE_BIT=7, FSM state enum.
REQ-033 One sub-module dragster_sync (parameterized multi-flop synchronizer) SHALL be instantiated per async input.

Verification
REQ-034 Write frame data 0x3B addr 0x05 -> one wr_strobe, wr_addr=5, wr_data=0x3B, regs[5]=0x3B, no frame_error.
REQ-035 Write 0xA1 to addr 0x01 -> wr_strobe and update_pulse in same cycle; write 0x21 to addr 1 -> no update_pulse.
REQ-036 With DRAGSTER_READBACK_EN, after REQ-034, read addr 0x85 -> miso returns 0x3B LSB first in bits 8-15, no wr_strobe; without macro -> miso stays 0.
REQ-037 ss_n raised after 10 bits of write to addr 2 -> frame_error pulse, regs[2] unchanged; next full frame accepted normally.
REQ-038 NUM_REGS=8, write 0x07 to addr 0x09 -> no wr_strobe, frame_error pulse; 20-bit frame to addr 3 -> exactly one write of first data byte.
REQ-039 reset_n asserted at bit 12 of a write -> no write; subsequent frame after reset release writes correctly.
